// File: rtl/cpu_pkg.sv
// cpu_pkg: shared datapath width, NZVC flag layout and flag bit indices.
package cpu_pkg;
  localparam int WIDTH = 64;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;
  typedef struct packed {
    logic n;
    logic z;
    logic v;
    logic c;
  } flags_t;
endpackage

// File: rtl/zero_detect.sv
// zero_detect: gate-level OR reduction tree with an inverting root, giving zero = ~|a.
module zero_detect #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  output wire              zero
);
  // Heap layout: leaves occupy WIDTH-1..2*WIDTH-2, node k ORs children 2k+1 and 2k+2.
  wire [2*WIDTH-2:0] node;
  for (genvar i = 0; i < WIDTH; i++) begin : g_leaf
    buf (node[WIDTH-1+i], a[i]);
  end
  for (genvar j = 0; j < WIDTH - 1; j++) begin : g_tree
    or (node[j], node[2*j+1], node[2*j+2]);
  end
  not (zero, node[0]);
endmodule

// File: rtl/ex_mem_flags.sv
// ex_mem_flags: EX/MEM pipeline register plus the architectural NZVC flag register with branch forwarding.
module ex_mem_flags #(
  parameter int WIDTH    = cpu_pkg::WIDTH,
  parameter int REG_BITS = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ex_valid,
  input  logic [WIDTH-1:0]    ex_result,
  input  logic                ex_overflow,
  input  logic                ex_carryout,
  input  logic                ex_set_flags,
  input  logic [REG_BITS-1:0] ex_rd,
  input  logic                ex_reg_write,
  input  logic                ex_mem_read,
  input  logic                ex_mem_write,
  input  logic [WIDTH-1:0]    ex_store_data,
  input  logic                stall,
  input  logic                flush,
  output logic                mem_valid,
  output logic [WIDTH-1:0]    mem_result,
  output logic [REG_BITS-1:0] mem_rd,
  output logic                mem_reg_write,
  output logic                mem_mem_read,
  output logic                mem_mem_write,
  output logic [WIDTH-1:0]    mem_store_data,
  output logic [3:0]          flags,
  output logic [3:0]          flags_fwd,
  output logic                ex_zero
);
  import cpu_pkg::*;
  wire    z_new;
  flags_t new_f;
  flags_t flags_q;
  zero_detect #(.WIDTH(WIDTH)) u_zero (.a(ex_result), .zero(z_new));
  assign ex_zero = z_new;
  assign new_f = '{n: ex_result[WIDTH-1], z: z_new, v: ex_overflow, c: ex_carryout};
  assign flags = flags_q;
  // Stall does not block forwarding: a stalled branch sees the same pending flags.
  assign flags_fwd = (ex_valid & ex_set_flags & ~flush) ? new_f : flags_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_valid      <= 1'b0;
      mem_result     <= '0;
      mem_rd         <= '0;
      mem_reg_write  <= 1'b0;
      mem_mem_read   <= 1'b0;
      mem_mem_write  <= 1'b0;
      mem_store_data <= '0;
    end else if (flush) begin
      mem_valid     <= 1'b0;
      mem_reg_write <= 1'b0;
      mem_mem_read  <= 1'b0;
      mem_mem_write <= 1'b0;
    end else if (!stall) begin
      mem_valid      <= ex_valid;
      mem_result     <= ex_result;
      mem_rd         <= ex_rd;
      mem_reg_write  <= ex_reg_write & ex_valid;
      mem_mem_read   <= ex_mem_read & ex_valid;
      mem_mem_write  <= ex_mem_write & ex_valid;
      mem_store_data <= ex_store_data;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) flags_q <= '0;
    else if (ex_valid & ex_set_flags & ~stall & ~flush) flags_q <= new_f;
  end
endmodule

// File: tb/tb_ex_mem_flags.sv
// tb_ex_mem_flags: directed vectors with hand-computed expectations for ex_mem_flags.
module tb_ex_mem_flags;
  import cpu_pkg::*;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ex_valid = 0, ex_overflow = 0, ex_carryout = 0, ex_set_flags = 0;
  logic [63:0] ex_result = '0, ex_store_data = '0;
  logic [4:0]  ex_rd = '0;
  logic        ex_reg_write = 0, ex_mem_read = 0, ex_mem_write = 0, stall = 0, flush = 0;
  logic        mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, ex_zero;
  logic [63:0] mem_result, mem_store_data;
  logic [4:0]  mem_rd;
  logic [3:0]  flags, flags_fwd;
  int total = 0;
  int bad = 0;

  ex_mem_flags dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_result(ex_result),
    .ex_overflow(ex_overflow), .ex_carryout(ex_carryout), .ex_set_flags(ex_set_flags),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_store_data(ex_store_data), .stall(stall),
    .flush(flush), .mem_valid(mem_valid), .mem_result(mem_result), .mem_rd(mem_rd),
    .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
    .mem_mem_write(mem_mem_write), .mem_store_data(mem_store_data), .flags(flags),
    .flags_fwd(flags_fwd), .ex_zero(ex_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [63:0] r, input logic ovf, input logic co,
                       input logic sf, input logic [4:0] rd, input logic rw, input logic mr,
                       input logic mw, input logic st, input logic fl);
    ex_valid = v; ex_result = r; ex_overflow = ovf; ex_carryout = co; ex_set_flags = sf;
    ex_rd = rd; ex_reg_write = rw; ex_mem_read = mr; ex_mem_write = mw;
    ex_store_data = r ^ 64'hA5A5; stall = st; flush = fl;
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #12;
    check("rst_valid", mem_valid, 0);
    check("rst_result", mem_result, 0);
    check("rst_flags", flags, 4'b0000);
    check("rst_rw", mem_reg_write, 0);
    @(negedge clk);
    reset = 1'b0;
    // ADDS 7FFF..F + 1: N=1 Z=0 V=1 C=0
    drive(1, 64'h8000_0000_0000_0000, 1, 0, 1, 5'd3, 1, 0, 0, 0, 0);
    #1;
    check("adds_fwd", flags_fwd, 4'b1010);
    check("adds_zero", ex_zero, 0);
    edge_sample();
    check("adds_flags", flags, 4'b1010);
    check("adds_result", mem_result, 64'h8000_0000_0000_0000);
    check("adds_valid", mem_valid, 1);
    check("adds_rd", mem_rd, 3);
    check("adds_sd", mem_store_data, 64'h8000_0000_0000_0000 ^ 64'hA5A5);
    // ADD without set_flags, result 0 with carry
    @(negedge clk);
    drive(1, 64'h0, 0, 1, 0, 5'd5, 1, 0, 0, 0, 0);
    #1;
    check("add_zero", ex_zero, 1);
    check("add_fwd", flags_fwd, 4'b1010);
    edge_sample();
    check("add_flags", flags, 4'b1010);
    check("add_rw", mem_reg_write, 1);
    check("add_rd", mem_rd, 5);
    // SUBS giving 0 with carry, stalled two cycles
    @(negedge clk);
    drive(1, 64'h0, 0, 1, 1, 5'd7, 1, 1, 0, 1, 0);
    for (int i = 0; i < 2; i++) begin
      #1;
      check("stall_fwd", flags_fwd, 4'b0101);
      edge_sample();
      check("stall_flags", flags, 4'b1010);
      check("stall_rd", mem_rd, 5);
      check("stall_mr", mem_mem_read, 0);
      @(negedge clk);
    end
    stall = 0;
    #1;
    check("unstall_fwd", flags_fwd, 4'b0101);
    edge_sample();
    check("unstall_flags", flags, 4'b0101);
    check("unstall_rd", mem_rd, 7);
    check("unstall_mr", mem_mem_read, 1);
    // flush overrides stall
    @(negedge clk);
    drive(1, 64'h5, 0, 0, 1, 5'd9, 1, 0, 1, 1, 1);
    #1;
    check("flush_fwd", flags_fwd, 4'b0101);
    edge_sample();
    check("flush_valid", mem_valid, 0);
    check("flush_mw", mem_mem_write, 0);
    check("flush_rw", mem_reg_write, 0);
    check("flush_mr", mem_mem_read, 0);
    check("flush_flags", flags, 4'b0101);
    // bubble with reg_write and set_flags asserted
    @(negedge clk);
    drive(0, 64'h0, 1, 0, 1, 5'd11, 1, 1, 1, 0, 0);
    #1;
    check("bubble_fwd", flags_fwd, 4'b0101);
    check("bubble_zero", ex_zero, 1);
    edge_sample();
    check("bubble_rw", mem_reg_write, 0);
    check("bubble_mr", mem_mem_read, 0);
    check("bubble_mw", mem_mem_write, 0);
    check("bubble_valid", mem_valid, 0);
    check("bubble_flags", flags, 4'b0101);
    // back-to-back ADDS overwrite
    @(negedge clk);
    drive(1, 64'h1, 0, 0, 1, 5'd1, 1, 0, 0, 0, 0);
    edge_sample();
    check("b2b_a_flags", flags, 4'b0000);
    @(negedge clk);
    drive(1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 1, 5'd2, 1, 0, 1, 0, 0);
    edge_sample();
    check("b2b_b_flags", flags, 4'b1001);
    check("b2b_b_mw", mem_mem_write, 1);
    // load flags 1011 with mem_valid=1, then reset between edges
    @(negedge clk);
    drive(1, 64'h8000_0000_0000_0000, 1, 1, 1, 5'd4, 1, 0, 0, 0, 0);
    edge_sample();
    check("pre_rst_flags", flags, 4'b1011);
    check("pre_rst_valid", mem_valid, 1);
    #2;
    stall = 1;
    reset = 1;
    #1;
    check("async_valid", mem_valid, 0);
    check("async_flags", flags, 4'b0000);
    check("async_result", mem_result, 0);
    check("async_rd", mem_rd, 0);
    check("async_rw", mem_reg_write, 0);
    check("async_sd", mem_store_data, 0);
    @(negedge clk);
    reset = 0;
    drive(1, 64'h0, 0, 1, 1, 5'd6, 0, 1, 0, 0, 0);
    edge_sample();
    check("post_rst_valid", mem_valid, 1);
    check("post_rst_flags", flags[FLAG_Z] ? 4'b0101 : flags, 4'b0101);
    check("post_rst_c", flags[FLAG_C], 1);
    check("post_rst_mr", mem_mem_read, 1);
    check("post_rst_rd", mem_rd, 6);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
